// File: rtl/spm_copy_master.sv
// Avalon-MM master that copies a block of words within a single-port scratchpad, one RD/LAT/WR triple per word.
// Define SPM_COPY_CRC_EN to run a CRC-32 (poly 0x04C11DB7, MSB first, no final XOR) over the copied words.
module spm_copy_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         crc,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    output logic                clken
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_FIN} state_t;

    localparam int unsigned MAX_LEN = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, idx_inc;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              err_q, err_d;
    logic              len_bad, start_ok;

    assign len_bad  = 32'(length) > MAX_LEN;
    assign start_ok = (state_q == S_IDLE) && start && !len_bad;
    assign idx_inc  = idx_q + LEN_W'(1);

    // NOTE: every always_comb target gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        idx_d       = idx_q;
        writedata_d = writedata_q;
        err_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                err_d = start && len_bad;
                if (start_ok) begin
                    if (length == '0) begin
                        state_d = S_FIN;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = length;
                        idx_d   = '0;
                        state_d = S_RD;
                    end
                end
            end
            S_RD:  state_d = abort ? S_IDLE : S_LAT;
            S_LAT: begin
                writedata_d = readdata;
                state_d     = abort ? S_IDLE : S_WR;
            end
            S_WR: begin
                idx_d = idx_inc;
                if (abort)                 state_d = S_IDLE;
                else if (idx_inc == len_q) state_d = S_FIN;
                else                       state_d = S_RD;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes decode straight from the state so an async reset clears them in the same cycle.
    always_comb begin
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        case (state_q)
            S_RD: begin
                chipselect = 1'b1;
                address    = src_q + idx_q[ADDR_W-1:0];
            end
            S_LAT: address = src_q + idx_q[ADDR_W-1:0];
            S_WR: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = dst_q + idx_q[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign err        = err_q;
    assign writedata  = writedata_q;
    assign byteenable = '1;
    assign clken      = 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            writedata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            writedata_q <= writedata_d;
            err_q       <= err_d;
        end
    end

`ifdef SPM_COPY_CRC_EN
    function automatic logic [31:0] crc32_word(input logic [31:0] c_in, input logic [DATA_W-1:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = DATA_W - 1; b >= 0; b--)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d[b]) ? 32'h04C1_1DB7 : 32'h0);
        return c;
    endfunction

    logic [31:0] crc_q, crc_d;

    // The word folded in during WR is the registered copy that is on writedata that cycle.
    always_comb begin
        crc_d = crc_q;
        if (start_ok)
            crc_d = '1;
        else if (state_q == S_WR)
            crc_d = crc32_word(crc_q, writedata_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) crc_q <= '1;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
`else
    assign crc = 32'h0;
`endif

endmodule

// File: tb/tb_spm_copy_master.sv
// Directed bench for spm_copy_master: scratchpad model, per-cycle bus/status trace model and literal spot checks.
module tb_spm_copy_master;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 13;
`ifdef SPM_COPY_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam logic [31:0] CRC_RST = CRC_ON ? 32'hFFFF_FFFF : 32'h0;

    typedef struct packed {
        logic        busy, done, err, cs, we;
        logic [3:0]  be;
        logic        ck;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] crc;
    } cyc_t;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [ADDR_W-1:0] src_addr, dst_addr, address;
    logic [LEN_W-1:0]  length;
    logic              busy, done, err, chipselect, write, clken;
    logic [31:0]       crc;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata, readdata;

    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] rnd     [16];
    byte unsigned msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    cyc_t        exp_q[$];
    logic [31:0] m_crc;
    int n_vec = 0, n_err = 0, cyc = 0, cs_cnt = 0, done_cnt = 0;
    int done_cyc = -1, err_cyc = -1, t_start = 0;

    spm_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .err(err), .crc(crc),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata), .clken(clken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [31:0] d, input int nbits);
        logic [31:0] c;
        c = c_in;
        for (int b = nbits - 1; b >= 0; b--) begin
            if (c[31] ^ d[b]) c = (c << 1) ^ 32'h04C1_1DB7;
            else              c = c << 1;
        end
        return c;
    endfunction

    function automatic cyc_t idle(input logic [31:0] c);
        cyc_t e;
        e     = '0;
        e.be  = 4'hF;
        e.ck  = 1'b1;
        e.crc = c;
        return e;
    endfunction

    // Expected bus/status trace of one job, starting with the cycle the start is presented.
    task automatic build(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n, input int abort_word);
        cyc_t        e;
        logic [31:0] c, w;
        logic [11:0] sa, da;
        exp_q.push_back(idle(m_crc));
        if (n > 13'd4096) begin
            e = idle(m_crc); e.err = 1'b1; exp_q.push_back(e);
            return;
        end
        c = CRC_RST == 32'h0 ? 32'h0 : 32'hFFFF_FFFF;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + i[11:0];
            da = d + i[11:0];
            w  = ref_mem[sa];
            e = idle(c); e.busy = 1'b1; e.cs = 1'b1; e.addr = sa; exp_q.push_back(e);
            e.cs = 1'b0; exp_q.push_back(e);
            e.cs = 1'b1; e.we = 1'b1; e.addr = da; e.wdata = w; exp_q.push_back(e);
            ref_mem[da] = w;
            if (CRC_ON) c = crc_model(c, w, 32);
            if (i == abort_word) begin
                m_crc = c;
                return;
            end
        end
        e = idle(c); e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
        m_crc = c;
    endtask

    task automatic monitor();
        cyc_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = idle(m_crc);
            a.busy = busy; a.done = done; a.err = err; a.cs = chipselect; a.we = write;
            a.be = byteenable; a.ck = clken; a.addr = address;
            a.wdata = write ? writedata : 32'h0;
            a.crc = crc;
            check($sformatf("cycle%0d", cyc), 128'(a), 128'(e));
            if (chipselect) cs_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cyc = cyc;
        end
    endtask

    // Single-port scratchpad: bus sampled mid-cycle, acted on just after the edge.
    task automatic spm();
        logic        cs_s, we_s;
        logic [11:0] a_s;
        logic [31:0] wd_s;
        forever begin
            @(negedge clk);
            cs_s = chipselect; we_s = write; a_s = address; wd_s = writedata;
            @(posedge clk);
            #1;
            if (cs_s) begin
                if (we_s) mem[a_s] = wd_s;
                else      readdata = mem[a_s];
            end
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic launch(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n, input int abort_word);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        t_start  = cyc + 1;
        build(s, d, n, abort_word);
        step(1);
        start = 1'b0; abort = 1'b0;
        src_addr = ~s; dst_addr = ~d; length = ~n;
    endtask

    task automatic run(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n);
        launch(s, d, n, -1);
        step((n == 13'd0 || n > 13'd4096) ? 3 : 3 * int'(n) + 3);
    endtask

    initial begin
        logic [31:0] c;
        int c0, d0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; readdata = '0;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 32'h0; ref_mem[a] = 32'h0;
        end
        m_crc = CRC_RST;
        fork
            monitor();
            spm();
        join_none

        c = 32'hFFFF_FFFF;
        foreach (msg[k]) c = crc_model(c, {24'h0, msg[k]}, 8);
        check("crc_model_pin", c, 32'h0376_E6E7);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_outputs", {busy, done, err, chipselect, write, address, writedata, crc},
              {5'b0, 12'h0, 32'h0, CRC_RST});
        step(2);

        // basic copy
        poke(12'h000, 32'h1111_1111); poke(12'h001, 32'h2222_2222);
        poke(12'h002, 32'h3333_3333); poke(12'h003, 32'h4444_4444);
        c0 = cs_cnt; d0 = done_cnt;
        run(12'h000, 12'h100, 13'd4);
        check("basic_w0", mem[12'h100], 32'h1111_1111);
        check("basic_w1", mem[12'h101], 32'h2222_2222);
        check("basic_w2", mem[12'h102], 32'h3333_3333);
        check("basic_w3", mem[12'h103], 32'h4444_4444);
        check("basic_done_at", done_cyc - t_start, 13);
        check("basic_cs_cycles", cs_cnt - c0, 8);
        check("basic_done_count", done_cnt - d0, 1);

        // zero length
        c0 = cs_cnt;
        run(12'h050, 12'h060, 13'd0);
        check("zero_done_at", done_cyc - t_start, 1);
        check("zero_cs_cycles", cs_cnt - c0, 0);
`ifdef SPM_COPY_CRC_EN
        check("zero_crc", crc, 32'hFFFF_FFFF);
`endif

        // wrap, with a start pulse while busy that must be ignored
        poke(12'hFFE, 32'hCAFE_0001); poke(12'hFFF, 32'hCAFE_0002); poke(12'h000, 32'hCAFE_0003);
        launch(12'hFFE, 12'h7FF, 13'd3, -1);
        step(3);
        src_addr = 12'h123; dst_addr = 12'h456; length = 13'd5; start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("wrap_7ff", mem[12'h7FF], 32'hCAFE_0001);
        check("wrap_800", mem[12'h800], 32'hCAFE_0002);
        check("wrap_801", mem[12'h801], 32'hCAFE_0003);

        // length one past the maximum
        c0 = cs_cnt;
        run(12'h000, 12'h900, 13'd4097);
        check("err_at", err_cyc - t_start, 1);
        check("err_cs_cycles", cs_cnt - c0, 0);
        check("err_no_write", mem[12'h900], 32'h0);

        // overlap, with abort alongside the accepted start
        for (int i = 0; i < 4; i++) poke(i[11:0], 32'hA0 + i);
        abort = 1'b1;
        run(12'h000, 12'h001, 13'd3);
        check("overlap_w1", mem[12'h001], 32'hA0);
        check("overlap_w2", mem[12'h002], 32'hA0);
        check("overlap_w3", mem[12'h003], 32'hA0);

        // abort during the second write
        for (int i = 0; i < 8; i++) poke(12'h200 + i[11:0], 32'hB000_0000 | i);
        d0 = done_cnt;
        launch(12'h200, 12'h300, 13'd8, 1);
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(4);
        check("abort_w0", mem[12'h300], 32'hB000_0000);
        check("abort_w1", mem[12'h301], 32'hB000_0001);
        check("abort_w2", mem[12'h302], 32'h0);
        check("abort_no_done", done_cnt - d0, 0);

        // reset in the RD of the second word
        for (int i = 0; i < 8; i++) poke(12'h400 + i[11:0], 32'hC000_0000 | i);
        launch(12'h400, 12'h500, 13'd8, 0);
        step(3);
        reset = 1'b1;
        m_crc = CRC_RST;
        #1;
        check("midreset_outputs", {busy, done, err, chipselect, write, address, writedata, crc},
              {5'b0, 12'h0, 32'h0, CRC_RST});
        step(1);
        reset = 1'b0;
        step(2);
        check("midreset_w0", mem[12'h500], 32'hC000_0000);
        check("midreset_w1", mem[12'h501], 32'h0);

        // random 16-word block for the CRC
        for (int i = 0; i < 16; i++) begin
            rnd[i] = $urandom;
            poke(12'h600 + i[11:0], rnd[i]);
        end
        run(12'h600, 12'h700, 13'd16);
        for (int i = 0; i < 16; i++) check($sformatf("crc_copy_w%0d", i), mem[12'h700 + i[11:0]], rnd[i]);
`ifdef SPM_COPY_CRC_EN
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) c = crc_model(c, rnd[i], 32);
        check("crc_16_words", crc, c);
`else
        check("crc_tied_off", crc, 32'h0);
`endif
        launch(12'h600, 12'h780, 13'd2, -1);
        @(negedge clk);
`ifdef SPM_COPY_CRC_EN
        check("crc_reinit", crc, 32'hFFFF_FFFF);
`else
        check("crc_reinit_off", crc, 32'h0);
`endif
        @(posedge clk);
        #1;
        step(7);

        // maximum legal length: whole scratchpad onto itself
        d0 = done_cnt;
        run(12'h000, 12'h000, 13'd4096);
        check("maxlen_done_count", done_cnt - d0, 1);
        check("maxlen_done_at", done_cyc - t_start, 3 * 4096 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
